pwm_gen: RTL and testbench
==========================

// Module: pwm_gen
// PURPOSE
//   Downstream consumer of the free-running counter: compares its count against a duty value to drive one PWM output.
//   Duty updates arrive over a valid/ready handshake and are double-buffered, applied only at a period boundary (glitch-free).
//   Start/stop are period-aligned, so the output never emits a truncated pulse.
// PARAMETERS
//   T   5000000          period in counts; must equal the counter's T; T >= 2
//   W   $clog2(T)        count width (derived, not overridden)
//   DW  $clog2(T+1)      duty width; duty range 0..T (0% .. 100%)
// PORTS
//   clk         in   1   clock
//   rst_        in   1   asynchronous reset, active-low
//   ena         in   1   same enable fed to the counter; count advances only when high
//   count       in   W   counter value, 0..T-1
//   start       in   1   pulse: request output begin at next period start
//   stop        in   1   pulse: request output end after current period
//   duty_valid  in   1   new duty offered
//   duty        in   DW  duty value; >T clamped to T
//   duty_ready  out  1   buffer slot free; transfer when duty_valid && duty_ready
//   pwm         out  1   PWM output, registered
//   running     out  1   high in RUN and DRAIN
//   period_pls  out  1   1-cycle pulse registered from boundary while running
// BEHAVIOUR
//   Reset: state=IDLE, active_duty=0, pending empty, pwm=0, running=0, period_pls=0, duty_ready=1.
//   boundary = ena && (count == T-1); the counter shows 0 on the following cycle.
//   Duty buffer: one pending entry + one active register.
//     - duty_ready = !pending_full; accept stores min(duty,T) into pending.
//     - On boundary with pending full: active_duty <= pending, pending cleared.
//     - Accept and boundary in the same cycle with pending empty: value bypasses to active_duty directly.
//     - Pending never overwritten; a held duty_valid waits for duty_ready.
//   FSM (pwm_state_t):
//     IDLE  : pwm=0. start -> ARMED.
//     ARMED : pwm=0. boundary -> RUN. stop -> IDLE (aborts arm).
//     RUN   : pwm <= (count < active_duty), one-cycle latency from count. stop -> DRAIN.
//     DRAIN : same as RUN until boundary -> IDLE (last period completes in full).
//     start and stop in the same cycle: stop wins.
//     start in RUN/DRAIN: ignored. stop in IDLE: ignored.
//   Compare rules: active_duty=0 -> pwm constant 0; active_duty=T -> constant 1 (count max T-1).
//     Compare at full DW width; count zero-extended.
//   ena low: count frozen, no boundary, FSM holds, pwm holds its last compare value; handshake still operates.
//   period_pls: asserted the cycle after boundary when state was RUN or DRAIN.
//   Async reset mid-period: all state returns to reset values immediately; pending duty discarded.
// STRUCTURE
//   pwm_pkg: typedef enum logic [1:0] pwm_state_t {IDLE, ARMED, RUN, DRAIN}.
//   Sub-module pwm_duty_buf: pending/active registers, clamp, bypass, ready logic.
//     Ports: clk, rst_, valid, duty, ready, boundary, active_duty.
//   Top: FSM, compare, output registers.
//   Width checks: elaboration-time assertion that T >= 2.
// TESTING (T=10, ena=1 unless stated)
//   Reset, then start at count=3, duty=4 preloaded -> pwm=0 until count wraps.
//     Then pwm=1 for counts 0..3, 0 for 4..9 (1-cycle lag); running=1 from boundary.
//   In RUN, offer duty=7 at count=2 -> accepted, duty_ready=0.
//     Current period stays at 4; the next period shows 7 high cycles; duty_ready=1 after boundary.
//   Duty offer on the boundary cycle (count=9) with empty pending -> new duty effective at count=0 the next cycle.
//     duty_ready stays 1.
//   duty=0 -> pwm constant 0; duty=10 -> constant 1; duty=15 -> clamped, constant 1.
//   stop at count=5 -> pwm completes period through count=9.
//     Then IDLE, pwm=0, running=0; start+stop same cycle -> stays IDLE.
//   ena low for 20 cycles mid-period -> count, pwm, state frozen.
//     Assert rst_ low mid-RUN -> pwm=0, pending cleared, IDLE immediately.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared types and helpers for the PWM generator slice.
//   pwm_state_t : output sequencer states (IDLE, ARMED, RUN, DRAIN)
//   clamp_duty  : limits a requested duty to the period length
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } pwm_state_t;

  localparam int PWM_T_DEFAULT = 32'sd5000000;

  // Duty above the period length means "always high", so it saturates at the limit.
  function automatic logic [31:0] clamp_duty(input logic [31:0] duty, input logic [31:0] limit);
    if (duty > limit) begin
      return limit;
    end else begin
      return duty;
    end
  endfunction

endpackage

// File: rtl/pwm_if.sv
// pwm_if
//   Bundles the counter view, start/stop controls, duty handshake and PWM outputs.
//   master : drives ena, count, start, stop, duty_valid, duty
//            (the counter / controller side); sees duty_ready, pwm, running, period_pls
//   slave  : the PWM generator
interface pwm_if
  import pwm_pkg::*;
#(
  parameter int T = PWM_T_DEFAULT
);
  localparam int W  = $clog2(T);
  localparam int DW = $clog2(T + 1);

  logic          ena;
  logic [W-1:0]  count;
  logic          start;
  logic          stop;
  logic          duty_valid;
  logic [DW-1:0] duty;
  logic          duty_ready;
  logic          pwm;
  logic          running;
  logic          period_pls;

  modport master (
    output ena, count, start, stop, duty_valid, duty,
    input  duty_ready, pwm, running, period_pls
  );

  modport slave (
    input  ena, count, start, stop, duty_valid, duty,
    output duty_ready, pwm, running, period_pls
  );

endinterface

// File: rtl/pwm_duty_buf.sv
// pwm_duty_buf
//   Double buffer for the PWM duty: one pending slot fed by a valid/ready
//   handshake and one active register that only changes on a period boundary.
//   clk, rst_    : clock, asynchronous active-low reset
//   valid, duty  : duty offer (duty above T is clamped to T)
//   ready        : pending slot is empty
//   boundary     : last count of the period with ena high
//   active_duty  : duty used by the compare for the current period
module pwm_duty_buf
  import pwm_pkg::*;
#(
  parameter int T = PWM_T_DEFAULT,
  localparam int DW = $clog2(T + 1)
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          valid,
  input  logic [DW-1:0] duty,
  output logic          ready,
  input  logic          boundary,
  output logic [DW-1:0] active_duty
);

  logic [DW-1:0] r_pend;
  logic          r_pend_full;
  logic [DW-1:0] r_active;
  logic          w_accept;
  logic [DW-1:0] w_clamped;

  assign w_accept    = valid && !r_pend_full;
  assign w_clamped   = DW'(clamp_duty(32'(duty), 32'(T)));
  assign ready       = !r_pend_full;
  assign active_duty = r_active;

  // Pending/active update: boundary promotes pending, or bypasses a same-cycle offer.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_active    <= '0;
    end else if (boundary) begin
      if (r_pend_full) begin
        // ready was low, so no offer can be accepted this cycle
        r_active    <= r_pend;
        r_pend_full <= 1'b0;
      end else if (w_accept) begin
        r_active <= w_clamped;
      end else begin
        r_active <= r_active;
      end
    end else if (w_accept) begin
      r_pend      <= w_clamped;
      r_pend_full <= 1'b1;
    end else begin
      r_pend_full <= r_pend_full;
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen
//   Compares the free-running count against a double-buffered duty to drive
//   one PWM output. Start and stop take effect on period boundaries so the
//   output never emits a truncated pulse.
//   clk, rst_ : clock, asynchronous active-low reset
//   bus       : pwm_if.slave -- ena/count from the counter, start/stop pulses,
//               duty valid/ready handshake, registered pwm/running/period_pls
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int T = PWM_T_DEFAULT
) (
  input  logic clk,
  input  logic rst_,
  pwm_if.slave bus
);

  localparam int W  = $clog2(T);
  localparam int DW = $clog2(T + 1);

  if (T < 2) begin : g_bad_period
    $error("pwm_gen: period T must be at least 2");
  end

  pwm_state_t    r_state;
  logic          r_pwm;
  logic          r_running;
  logic          r_period_pls;
  logic          w_boundary;
  logic          w_hit;
  logic          w_duty_ready;
  logic [DW-1:0] w_active_duty;

  assign w_boundary = bus.ena && (bus.count == W'(T - 1));
  // Count is zero-extended so active_duty == T keeps the output high on count T-1.
  assign w_hit      = (DW'(bus.count) < w_active_duty);

  pwm_duty_buf #(.T(T)) u_duty_buf (
    .clk         (clk),
    .rst_        (rst_),
    .valid       (bus.duty_valid),
    .duty        (bus.duty),
    .ready       (w_duty_ready),
    .boundary    (w_boundary),
    .active_duty (w_active_duty)
  );

  assign bus.duty_ready = w_duty_ready;
  assign bus.pwm        = r_pwm;
  assign bus.running    = r_running;
  assign bus.period_pls = r_period_pls;

  // Output sequencer with registered pwm, running and period pulse.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state      <= IDLE;
      r_pwm        <= 1'b0;
      r_running    <= 1'b0;
      r_period_pls <= 1'b0;
    end else begin
      r_period_pls <= w_boundary && ((r_state == RUN) || (r_state == DRAIN));
      case (r_state)
        IDLE: begin
          r_pwm     <= 1'b0;
          r_running <= 1'b0;
          if (bus.start && !bus.stop) begin
            r_state <= ARMED;
          end else begin
            r_state <= IDLE;
          end
        end
        ARMED: begin
          r_pwm <= 1'b0;
          if (bus.stop) begin
            r_state <= IDLE;
          end else if (w_boundary) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end else begin
            r_state <= ARMED;
          end
        end
        RUN: begin
          // pwm only follows the compare while the count advances
          if (bus.ena) begin
            r_pwm <= w_hit;
          end else begin
            r_pwm <= r_pwm;
          end
          // stop on the last count: the current period is already complete
          if (bus.stop && w_boundary) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end else if (bus.stop) begin
            r_state <= DRAIN;
          end else begin
            r_state <= RUN;
          end
        end
        DRAIN: begin
          if (bus.ena) begin
            r_pwm <= w_hit;
          end else begin
            r_pwm <= r_pwm;
          end
          if (w_boundary) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end else begin
            r_state <= DRAIN;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_pwm     <= 1'b0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen
//   Directed bench for pwm_gen with T=10. The stimulus side pushes the
//   expected {pwm, running, period_pls, duty_ready} for each cycle it drives;
//   a separate monitor pops and compares on the falling edge.
module tb_pwm_gen;

  localparam int T = 10;

  logic clk = 1'b0;
  logic rst_;

  always #5 clk = ~clk;

  pwm_if #(.T(T)) bus ();

  pwm_gen #(.T(T)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0] v;
    string      tag;
  } exp_t;

  exp_t       q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  exp_t       mon_e;
  logic [3:0] mon_act;

  // Monitor: one expectation per falling edge when one is pending.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e   = q.pop_front();
      mon_act = {bus.pwm, bus.running, bus.period_pls, bus.duty_ready};
      n_tests++;
      if (mon_act !== mon_e.v) begin
        n_fail++;
        $display("FAIL %s t=%0t count=%0d: pwm/run/pls/rdy got %b expected %b",
                 mon_e.tag, $time, bus.count, mon_act, mon_e.v);
      end
    end
  end

  // Upstream counter model: advances just after the edge, frozen when ena is low.
  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_) begin
      bus.count = 4'd0;
    end else if (bus.ena) begin
      bus.count = (bus.count == 4'(T - 1)) ? 4'd0 : bus.count + 4'd1;
    end
  endtask

  task automatic expect_now(input logic p, input logic r, input logic s, input logic y,
                            input string tag);
    exp_t e;
    e.v   = {p, r, s, y};
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic cyc(input logic p, input logic r, input logic s, input logic y,
                     input string tag);
    step();
    expect_now(p, r, s, y, tag);
  endtask

  // One running period, displayed counts 0..9. Output lags count by one cycle,
  // so count 0 still shows the previous period's last compare.
  task automatic run_period(input int d_prev, input int d, input logic pls0,
                            input int offer_at, input int offer_val, input string tag);
    logic p;
    logic y;
    int   ov;
    for (int c = 0; c < T; c++) begin
      step();
      bus.duty_valid = 1'b0;
      p = (c == 0) ? ((T - 1) < d_prev) : ((c - 1) < d);
      y = !((offer_at >= 0) && (offer_at < T - 1) && (c > offer_at));
      expect_now(p, 1'b1, (c == 0) ? pls0 : 1'b0, y, tag);
      if (c == offer_at) begin
        ov             = offer_val;
        bus.duty_valid = 1'b1;
        bus.duty       = ov[3:0];
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_           = 1'b0;
    bus.ena        = 1'b1;
    bus.count      = 4'd0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.duty_valid = 1'b0;
    bus.duty       = 4'd0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    expect_now(1'b0, 1'b0, 1'b0, 1'b1, "reset");
    rst_ = 1'b1;

    // Preload duty 4 into the pending slot, then start at count 3
    bus.duty_valid = 1'b1;
    bus.duty       = 4'd4;
    step();
    bus.duty_valid = 1'b0;
    expect_now(1'b0, 1'b0, 1'b0, 1'b0, "preload");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    bus.start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      bus.start = 1'b0;
      expect_now(1'b0, 1'b0, 1'b0, 1'b0, "armed");
    end

    // First period duty 4; duty 7 offered at count 2 is held pending
    run_period(0, 4, 1'b0, 2, 7, "p4");
    // Duty 7; offer 0 on the boundary cycle bypasses straight to active
    run_period(4, 7, 1'b1, 9, 0, "p7");
    run_period(7, 0, 1'b1, 9, 10, "p0");
    run_period(0, 10, 1'b1, 9, 15, "p10");

    // Duty 15 clamps to 10 (constant high); stop at count 5 drains the period
    for (int c = 0; c < T; c++) begin
      step();
      bus.duty_valid = 1'b0;
      bus.stop       = 1'b0;
      expect_now(1'b1, 1'b1, (c == 0) ? 1'b1 : 1'b0, 1'b1, "p15_drain");
      if (c == 5) begin
        bus.stop = 1'b1;
      end
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b1, "drain_end");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "idle_after");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "idle_after");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "idle_after");

    // start and stop together: stop wins, never arms
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      expect_now(1'b0, 1'b0, 1'b0, 1'b1, "start_stop");
    end

    // Re-arm with duty 6 pending (count now 5)
    bus.duty_valid = 1'b1;
    bus.duty       = 4'd6;
    bus.start      = 1'b1;
    step();
    bus.duty_valid = 1'b0;
    bus.start      = 1'b0;
    expect_now(1'b0, 1'b0, 1'b0, 1'b0, "arm2");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "arm2");
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b1, "run2_c0");
    for (int c = 1; c <= 6; c++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1, "run2");
    end

    // ena low at count 6: everything frozen, handshake still accepts duty 3
    bus.ena        = 1'b0;
    bus.duty_valid = 1'b1;
    bus.duty       = 4'd3;
    for (int i = 0; i < 20; i++) begin
      step();
      bus.duty_valid = 1'b0;
      expect_now(1'b1, 1'b1, 1'b0, 1'b0, "freeze");
    end
    bus.ena = 1'b1;
    for (int c = 7; c <= 9; c++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, "thaw");
    end
    run_period(6, 3, 1'b1, -1, 0, "p3");

    // Async reset mid-RUN with a pending duty
    cyc(1'b0, 1'b1, 1'b1, 1'b1, "pre_rst_c0");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, "pre_rst_c1");
    bus.duty_valid = 1'b1;
    bus.duty       = 4'd8;
    step();
    bus.duty_valid = 1'b0;
    rst_           = 1'b0;
    #1;
    expect_now(1'b0, 1'b0, 1'b0, 1'b1, "async_rst");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "in_rst");
    rst_ = 1'b1;

    // After reset: pending and active were cleared, so a new run is constant low
    bus.start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      bus.start = 1'b0;
      expect_now(1'b0, 1'b0, 1'b0, 1'b1, "arm3");
    end
    run_period(0, 0, 1'b0, -1, 0, "post_rst");

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
